// File: rtl/ws2812_loader.sv
// ws2812_loader: assembles R,G,B byte stream into per-LED writes for a WS2812 driver.
// Tracks the LED index within a frame, enforces an idle gap after each write,
// flags bytes that arrive after the frame is full, and resyncs on sof.
module ws2812_loader #(
  parameter int unsigned NUM_LEDS  = 144,
  parameter int unsigned WRITE_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        sof,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned CNT_W = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (WRITE_GAP == 0) ? '0 : GAP_W'(WRITE_GAP - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    GAP     = 2'd2,
    FULL    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         r_q, r_d;
  logic [7:0]         g_q, g_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               last_q, last_d;
  logic               pend_q, pend_d;
  logic [23:0]        rgb_d;
  logic [IDX_W-1:0]   led_d;
  logic               write_d;
  logic               fd_d;
  logic               ovf_d;
  logic               accept;
  logic               leave;

  // Ready is a pure decode of the state register.
  assign byte_ready = (state_q == COLLECT) || (state_q == FULL);
  assign accept     = byte_valid && byte_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      idx_q      <= '0;
      r_q        <= '0;
      g_q        <= '0;
      gap_q      <= '0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      rgb_data   <= 24'h000000;
      led_num    <= '0;
      write      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      r_q        <= r_d;
      g_q        <= g_d;
      gap_q      <= gap_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      rgb_data   <= rgb_d;
      led_num    <= led_d;
      write      <= write_d;
      frame_done <= fd_d;
      overflow   <= ovf_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    r_d     = r_q;
    g_d     = g_q;
    gap_d   = gap_q;
    last_d  = last_q;
    pend_d  = pend_q;
    rgb_d   = rgb_data;
    led_d   = led_num;
    write_d = 1'b0;
    fd_d    = 1'b0;
    ovf_d   = overflow;
    leave   = 1'b0;

    case (state_q)
      COLLECT, FULL: begin
        if (sof) begin
          // Resync: a byte on the same edge becomes byte 0 of the new frame.
          state_d = COLLECT;
          idx_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          if (accept) begin
            r_d   = byte_data;
            cnt_d = CNT_W'(1);
          end
        end else if (accept) begin
          if (state_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            case (cnt_q)
              2'd0: begin
                r_d   = byte_data;
                cnt_d = CNT_W'(1);
              end
              2'd1: begin
                g_d   = byte_data;
                cnt_d = CNT_W'(2);
              end
              default: begin
                rgb_d   = {r_q, g_q, byte_data};
                led_d   = idx_q;
                write_d = 1'b1;
                fd_d    = (idx_q == LAST_IDX);
                last_d  = (idx_q == LAST_IDX);
                cnt_d   = '0;
                state_d = WRITE;
              end
            endcase
          end
        end
      end

      WRITE: begin
        // Index never wraps past the last LED.
        if (!last_q) begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (WRITE_GAP == 0) begin
          leave = 1'b1;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
          pend_d  = pend_q || sof;
        end
      end

      GAP: begin
        pend_d = pend_q || sof;
        if (gap_q == '0) begin
          leave = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase

    // Exit from the write/gap sequence, applying any resync seen meanwhile.
    if (leave) begin
      pend_d = 1'b0;
      if (pend_q || sof) begin
        state_d = COLLECT;
        idx_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        state_d = last_q ? FULL : COLLECT;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_loader.sv
// Testbench for ws2812_loader: directed byte streams, scoreboard of expected writes.
module tb_ws2812_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        sof;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        frame_done;
  logic        overflow;

  typedef struct packed {
    logic [23:0] rgb;
    logic [7:0]  led;
    logic        fd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ws2812_loader #(.NUM_LEDS(144), .WRITE_GAP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .sof        (sof),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .write      (write),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one byte, wait for ready, hold across the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic s);
    int n;
    n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    sof        = 1'b0;
    while (!byte_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
    sof = s;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    sof        = 1'b0;
  endtask

  // Send one LED and queue the write it must produce.
  task automatic send_led(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] led, input logic fd, input logic s);
    exp_t e;
    send_byte(r, s);
    send_byte(g, 1'b0);
    e.rgb = {r, g, b};
    e.led = led;
    e.fd  = fd;
    sb.push_back(e);
    send_byte(b, 1'b0);
    chk("write_latency", 32'(write), 32'd1);
  endtask

  initial begin
    exp_t e;
    reset      = 1'b0;
    byte_data  = 8'hEE;
    byte_valid = 1'b1;
    sof        = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          if (write) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: led_num=%0d rgb=%h, none expected", led_num, rgb_data);
            end else begin
              e = sb.pop_front();
              chk("sb_rgb", 32'(rgb_data), 32'(e.rgb));
              chk("sb_led", 32'(led_num), 32'(e.led));
              chk("sb_frame_done", 32'(frame_done), 32'(e.fd));
            end
          end else begin
            chk("frame_done_without_write", 32'(frame_done), 32'd0);
          end
        end
      end
    join_none

    // Reset state, with a byte presented that must be ignored.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_rgb", 32'(rgb_data), 32'd0);
    chk("rst_led", 32'(led_num), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk); #1;

    // First LED: latency and ready-low window of 1+4 cycles.
    send_led(8'h10, 8'h20, 8'h30, 8'd0, 1'b0, 1'b0);
    chk("busy_write", 32'(byte_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("busy_gap", 32'(byte_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("ready_after_gap", 32'(byte_ready), 32'd1);

    // Partial LED discarded by sof carrying the new byte 0.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_led(8'hAA, 8'hBB, 8'hCC, 8'd0, 1'b0, 1'b1);

    // LEDs 1..5, then sof during the gap after LED 5.
    for (int i = 1; i <= 5; i++) begin
      send_led(8'(i), 8'(i + 16), 8'(i + 32), 8'(i), 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
    chk("gap_still_busy", 32'(byte_ready), 32'd0);
    send_led(8'h77, 8'h88, 8'h99, 8'd0, 1'b0, 1'b0);

    // Full frame of 144 LEDs.
    for (int i = 0; i < 144; i++) begin
      send_led(8'(i), 8'(i + 1), 8'(255 - i), 8'(i), (i == 143), (i == 0));
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("full_ready", 32'(byte_ready), 32'd1);
    chk("full_no_ovf", 32'(overflow), 32'd0);

    // Extra byte after full frame sets overflow and writes nothing.
    send_byte(8'h55, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("full_ready_hold", 32'(byte_ready), 32'd1);
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    send_led(8'h01, 8'h02, 8'h03, 8'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write pulse.
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    chk("pre_reset_write", 32'(write), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_write", 32'(write), 32'd0);
    chk("async_rgb", 32'(rgb_data), 32'd0);
    chk("async_led", 32'(led_num), 32'd0);
    chk("async_fd", 32'(frame_done), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    chk("async_ready", 32'(byte_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    send_led(8'hC1, 8'hC2, 8'hC3, 8'd0, 1'b0, 1'b0);

    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
